ryg_monitor: RTL

Signal-side checker for the two-direction traffic-light controller. It samples the 6-bit lamp bus {R[1:0], Y[1:0], G[1:0]}, decodes it into the current phase, and locks onto the A→B→C→D cycle. It flags illegal lamp patterns, out-of-order phases and wrong phase durations. It sits downstream of the controller, on the lamp-driver side, as the receiving end of the RYG bus.

---
 rtl/ryg_pkg.sv | 50 +++++
 rtl/ryg_decode.sv | 35 +++
 rtl/ryg_monitor.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/ryg_pkg.sv
// ============================================================================
//  Module  : ryg_pkg
//  Purpose : Shared types and constants for the RYG lamp-bus monitor.
//            Phase encoding, legal lamp patterns, error codes, monitor FSM
//            states and a phase-successor helper.
//  Ports   : none (package)
//  Config  : none
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package ryg_pkg;

    // Traffic phases in cycle order A -> B -> C -> D -> A
    typedef enum logic [1:0] {
        PH_A = 2'd0,
        PH_B = 2'd1,
        PH_C = 2'd2,
        PH_D = 2'd3
    } phase_e;

    // Lamp bus layout {R1,R0,Y1,Y0,G1,G0}
    localparam logic [5:0] PAT_A = 6'h12;  // R0, G1
    localparam logic [5:0] PAT_B = 6'h18;  // R0, Y1
    localparam logic [5:0] PAT_C = 6'h21;  // R1, G0
    localparam logic [5:0] PAT_D = 6'h24;  // R1, Y0

    typedef enum logic [2:0] {
        ERR_NONE      = 3'd0,
        ERR_ILLEGAL   = 3'd1,
        ERR_ORDER     = 3'd2,
        ERR_TOO_LONG  = 3'd3,
        ERR_TOO_SHORT = 3'd4
    } err_code_e;

    typedef enum logic {
        MON_HUNT   = 1'b0,
        MON_LOCKED = 1'b1
    } mon_state_e;

    // Phase that must follow p; wraps D -> A
    function automatic phase_e ryg_next_phase(input phase_e p);
        logic [1:0] n;
        n = p + 2'd1;
        return phase_e'(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ryg_decode.sv
// ============================================================================
//  Module  : ryg_decode
//  Purpose : Combinational decode of a 6-bit lamp pattern into a phase and a
//            legality flag. Illegal patterns report PH_A with legal=0.
//  Ports   : pattern [5:0] in  - lamp bus {R1,R0,Y1,Y0,G1,G0}
//            phase   [1:0] out - decoded phase (valid only when legal)
//            legal         out - pattern is one of the four legal patterns
//  Config  : none
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ryg_decode
    import ryg_pkg::*;
(
    input  logic [5:0] pattern,
    output phase_e     phase,
    output logic       legal
);

    always_comb begin
        phase = PH_A;
        legal = 1'b1;
        case (pattern)
            PAT_A:   phase = PH_A;
            PAT_B:   phase = PH_B;
            PAT_C:   phase = PH_C;
            PAT_D:   phase = PH_D;
            default: legal = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ryg_monitor.sv
// ============================================================================
//  Module  : ryg_monitor
//  Purpose : Receiving-end checker for the RYG lamp bus. Captures the bus,
//            decodes the phase, locks onto the A->B->C->D cycle and flags
//            illegal patterns, out-of-order phases and bad phase durations.
//  Ports   : clk                 in  - rising-edge clock
//            reset               in  - asynchronous, active-low
//            RYG [5:0]           in  - lamp bus {R1,R0,Y1,Y0,G1,G0}
//            phase [1:0]         out - last legal phase (0=A..3=D)
//            phase_valid         out - current sample is a legal pattern
//            locked              out - synchronised to the phase cycle
//            err                 out - one-cycle pulse per fault
//            err_code [2:0]      out - code of the most recent fault
//            err_cnt [ERR_CNT_W] out - saturating fault count
//  Config  : RYG_MON_DURATION_CHECK_EN - builds the run counter and enables
//            the too-long (3) / too-short (4) duration faults.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module ryg_monitor
    import ryg_pkg::*;
#(
    parameter int unsigned GREEN_LEN  = 6,
    parameter int unsigned YELLOW_LEN = 2,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           RYG,
    output logic [1:0]           phase,
    output logic                 phase_valid,
    output logic                 locked,
    output logic                 err,
    output logic [2:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    // The run counter saturates at GREEN_LEN+1, so a yellow phase can only
    // be measured as too long if YELLOW_LEN does not exceed GREEN_LEN.
    if (GREEN_LEN < 1 || YELLOW_LEN < 1 || YELLOW_LEN > GREEN_LEN) begin : g_len_check
        $error("ryg_monitor: phase lengths must satisfy 1 <= YELLOW_LEN <= GREEN_LEN");
    end

    localparam logic [ERR_CNT_W-1:0] CNT_ONE = ERR_CNT_W'(1);

    logic [5:0]           ryg_q;
    logic                 sampled;     // ryg_q holds a real bus sample, not the reset value
    logic                 ill_q;       // previous sample was illegal
    logic                 have_phase;  // a legal phase has been seen since reset
    phase_e               last_phase;
    logic                 valid_q;
    mon_state_e           state;
    mon_state_e           state_nxt;
    logic                 err_q;
    err_code_e            code_q;
    err_code_e            fault_code;
    logic [ERR_CNT_W-1:0] cnt_q;

    phase_e               cur_phase;
    logic                 cur_legal;
    logic                 legal_s;
    logic                 illegal_s;
    logic                 changed;
    logic                 is_succ;
    logic                 too_long;
    logic                 too_short;

    ryg_decode u_decode (
        .pattern (ryg_q),
        .phase   (cur_phase),
        .legal   (cur_legal)
    );

    assign legal_s   = sampled & cur_legal;
    assign illegal_s = sampled & ~cur_legal;
    // Compared against the last legal phase, so an illegal gap does not hide
    // or fake a transition.
    assign changed   = legal_s & have_phase & (cur_phase != last_phase);
    assign is_succ   = (cur_phase == ryg_next_phase(last_phase));

`ifdef RYG_MON_DURATION_CHECK_EN
    localparam int unsigned       RUN_W      = $clog2(GREEN_LEN + 2);
    localparam logic [RUN_W-1:0] RUN_ONE    = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_MAX    = RUN_W'(GREEN_LEN + 1);
    localparam logic [RUN_W-1:0] GREEN_RUN  = RUN_W'(GREEN_LEN);
    localparam logic [RUN_W-1:0] YELLOW_RUN = RUN_W'(YELLOW_LEN);

    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_nxt;
    logic [RUN_W-1:0] exp_cur;
    logic [RUN_W-1:0] exp_last;

    always_comb begin
        exp_cur  = (cur_phase == PH_A || cur_phase == PH_C) ? GREEN_RUN : YELLOW_RUN;
        exp_last = (last_phase == PH_A || last_phase == PH_C) ? GREEN_RUN : YELLOW_RUN;
        run_nxt  = run_q;
        if (legal_s) begin
            if (!have_phase || changed) begin
                run_nxt = RUN_ONE;
            end else if (run_q != RUN_MAX) begin
                run_nxt = run_q + RUN_ONE;
            end
        end
        // The counter passes expected+1 exactly once per phase, and the
        // resulting fault drops lock, so this fires at most once per phase.
        too_long  = (state == MON_LOCKED) & legal_s & ~changed & (run_nxt == exp_cur + RUN_ONE);
        too_short = (state == MON_LOCKED) & changed & (run_q < exp_last);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_q <= '0;
        end else begin
            run_q <= run_nxt;
        end
    end
`else
    assign too_long  = 1'b0;
    assign too_short = 1'b0;
`endif

    // Fault priority: illegal > order > too short > too long
    always_comb begin
        fault_code = ERR_NONE;
        if (illegal_s && !ill_q) begin
            fault_code = ERR_ILLEGAL;
        end else if (state == MON_LOCKED && changed && !is_succ) begin
            fault_code = ERR_ORDER;
        end else if (too_short) begin
            fault_code = ERR_TOO_SHORT;
        end else if (too_long) begin
            fault_code = ERR_TOO_LONG;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MON_HUNT: begin
                if (changed && is_succ) begin
                    state_nxt = MON_LOCKED;
                end
            end
            MON_LOCKED: begin
                if (fault_code != ERR_NONE) begin
                    state_nxt = MON_HUNT;
                end
            end
            default: state_nxt = MON_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MON_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ryg_q      <= '0;
            sampled    <= 1'b0;
            ill_q      <= 1'b0;
            have_phase <= 1'b0;
            last_phase <= PH_A;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= ERR_NONE;
            cnt_q      <= '0;
        end else begin
            ryg_q   <= RYG;
            sampled <= 1'b1;
            ill_q   <= illegal_s;
            valid_q <= legal_s;
            if (legal_s) begin
                last_phase <= cur_phase;
                have_phase <= 1'b1;
            end
            err_q <= (fault_code != ERR_NONE);
            if (fault_code != ERR_NONE) begin
                code_q <= fault_code;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + CNT_ONE;
                end
            end
        end
    end

    assign phase       = last_phase;
    assign phase_valid = valid_q;
    assign locked      = (state == MON_LOCKED);
    assign err         = err_q;
    assign err_code    = code_q;
    assign err_cnt     = cnt_q;

endmodule

`default_nettype wire
